idex_skid_stage: RTL and testbench
==================================

// Module: idex_skid_stage
// PURPOSE
//  Parametrised ID/EX pipeline stage register with a valid/ready handshake and a 1-entry skid buffer.
//  Sits between decode and execute, replacing the free-running stage register.
//  Adds back-pressure, flush, bubble (control-NOP) insertion and a saturating stall counter.
//  The payload is {WB, M, EX, DataA, DataB, imm_value, RegRs, RegRt, RegRd, OpCode}.
// PARAMETERS
//  DATA_W  32  width of DataA/DataB/imm_value
//  REG_W   5   register-specifier width (Rs/Rt/Rd)
//  OP_W    6   opcode width
//  WB_W    2   write-back control width
//  M_W     3   memory control width
//  EX_W    4   execute control width
//  CNT_W   16  stall counter width
// PORTS
//  clock        in   1       clock; all state updates on its rising edge
//  rst          in   1       asynchronous, active-high reset
//  in_valid     in   1       decode presents a payload
//  in_ready     out  1       stage can accept; = !skid_valid
//  bubble       in   1       accepted entry has WB/M/EX forced to 0
//  flush        in   1       synchronous kill of all held entries
//  WB,M,EX      in   WB_W,M_W,EX_W   control fields
//  DataA,DataB,imm_value  in  DATA_W  operands
//  RegRs,RegRt,RegRd      in  REG_W   register specifiers
//  OpCode       in   OP_W    opcode
//  out_valid    out  1       execute payload valid
//  out_ready    in   1       execute consumes the payload
//  WBreg,Mreg,EXreg,DataAreg,DataBreg,imm_valuereg,RegRsreg,RegRtreg,RegRdreg,RegOpCode  out  as inputs
//  stall_cnt    out  CNT_W   cycles with out_valid && !out_ready, saturating
// BEHAVIOUR
//  Reset (async, rst=1): all outputs and both entries = 0; out_valid=0, stall_cnt=0, in_ready=1.
//  Handshakes: accept = in_valid && in_ready; consume = out_valid && out_ready.
//  Latency: 1 cycle, input to output, when the stage is empty or draining.
//  States, from {main_valid, skid_valid}:
//   EMPTY: accept -> main loads -> FULL.
//   FULL:
//    accept && consume   -> main reloads, stays FULL.
//    accept && !consume  -> payload goes to skid -> SKID.
//    !accept && consume  -> EMPTY.
//   SKID: in_ready=0.
//    consume -> main <= skid, skid clears -> FULL.
//    otherwise hold.
//  Illegal {0,1} is never reached.
//  Outputs are registered only; no input reaches any output combinationally.
//  Order is preserved: skid contents always reach main before any newer payload.
//  bubble: applies only when accept; the WB/M/EX captured = 0; other fields pass unchanged.
//  bubble without accept is ignored.
//  flush: at the next edge main_valid=skid_valid=0; WB/M/EX in both entries = 0.
//   Flush beats a simultaneous accept, and the accepted payload is dropped.
//   consume in the same cycle is still counted as done by execute.
//  When out_valid=0, WBreg/Mreg/EXreg read 0.
//   Data/specifier outputs hold their last value; they are don't-care.
//  stall_cnt: +1 on each cycle with out_valid && !out_ready; saturates at all-ones.
//   Cleared only by rst; flush does not clear it.
//  rst asserted mid-transfer: everything clears immediately; the in-flight payload is lost.
// STRUCTURE
//  idex_pkg:
//   width localparams matching the defaults;
//   packed struct idex_payload_t {wb, m, ex, data_a, data_b, imm, rs, rt, rd, op};
//   function ctrl_nop() that zeroes wb/m/ex.
//  Sub-module pipe_skid_reg #(PAYLOAD_W):
//   generic 2-entry elastic register (main + skid, in/out handshakes, flush).
//  idex_skid_stage:
//   packs/unpacks the payload, applies bubble/ctrl masking, holds stall_cnt.
// TESTING
//  1 Reset:
//   rst pulse mid-cycle with in_valid=1 -> all outputs 0, in_ready=1 asynchronously.
//  2 Streaming:
//   out_ready=1, DataA=1..8 on consecutive cycles
//   -> DataAreg=1..8 one cycle later, no gaps, in_ready stays 1.
//  3 Backpressure:
//   out_ready=0 after DataA=0xA,0xB accepted -> in_ready=0, DataAreg=0xA held.
//   Release -> 0xA then 0xB delivered in order; stall_cnt = number of stalled cycles.
//  4 Bubble:
//   bubble=1 with WB=2'b11, M=3'b101, EX=4'hF, DataA=0x55
//   -> WBreg=0, Mreg=0, EXreg=0, DataAreg=0x55, out_valid=1.
//  5 Flush in SKID state, with in_valid=1 the same cycle
//   -> next cycle out_valid=0, in_ready=1, EXreg=0.
//   Nothing from before the flush emerges later.
//  6 Saturation:
//   CNT_W=4, hold out_ready=0 for 20 cycles -> stall_cnt=4'hF and stays there.

Source files
------------

// File: rtl/idex_pkg.sv
// Shared widths, FSM state encoding and payload layout for the ID/EX skid stage.
// The payload struct describes the default-width layout; ctrl_nop turns an entry into a control NOP.
package idex_pkg;

    localparam int IDEX_DATA_W = 32;
    localparam int IDEX_REG_W  = 5;
    localparam int IDEX_OP_W   = 6;
    localparam int IDEX_WB_W   = 2;
    localparam int IDEX_M_W    = 3;
    localparam int IDEX_EX_W   = 4;
    localparam int IDEX_CNT_W  = 16;

    // Encoding is {main_valid, skid_valid}; {0,1} cannot occur.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_FULL  = 2'b10,
        ST_SKID  = 2'b11
    } skid_state_e;

    typedef struct packed {
        logic [IDEX_WB_W-1:0]   wb;
        logic [IDEX_M_W-1:0]    m;
        logic [IDEX_EX_W-1:0]   ex;
        logic [IDEX_DATA_W-1:0] data_a;
        logic [IDEX_DATA_W-1:0] data_b;
        logic [IDEX_DATA_W-1:0] imm;
        logic [IDEX_REG_W-1:0]  rs;
        logic [IDEX_REG_W-1:0]  rt;
        logic [IDEX_REG_W-1:0]  rd;
        logic [IDEX_OP_W-1:0]   op;
    } idex_payload_t;

    function automatic idex_payload_t ctrl_nop(input idex_payload_t p);
        idex_payload_t r;
        r    = p;
        r.wb = '0;
        r.m  = '0;
        r.ex = '0;
        return r;
    endfunction

endpackage

// File: rtl/idex_skid_stage_if.sv
// Decode-side and execute-side signals of the ID/EX stage, bundled as one interface.
// master drives decode inputs and out_ready; slave is the stage itself.
interface idex_skid_stage_if
    import idex_pkg::*;
#(
    parameter int DATA_W = IDEX_DATA_W,
    parameter int REG_W  = IDEX_REG_W,
    parameter int OP_W   = IDEX_OP_W,
    parameter int WB_W   = IDEX_WB_W,
    parameter int M_W    = IDEX_M_W,
    parameter int EX_W   = IDEX_EX_W,
    parameter int CNT_W  = IDEX_CNT_W
) ();

    logic              in_valid;
    logic              in_ready;
    logic              bubble;
    logic              flush;
    logic [WB_W-1:0]   WB;
    logic [M_W-1:0]    M;
    logic [EX_W-1:0]   EX;
    logic [DATA_W-1:0] DataA;
    logic [DATA_W-1:0] DataB;
    logic [DATA_W-1:0] imm_value;
    logic [REG_W-1:0]  RegRs;
    logic [REG_W-1:0]  RegRt;
    logic [REG_W-1:0]  RegRd;
    logic [OP_W-1:0]   OpCode;

    logic              out_valid;
    logic              out_ready;
    logic [WB_W-1:0]   WBreg;
    logic [M_W-1:0]    Mreg;
    logic [EX_W-1:0]   EXreg;
    logic [DATA_W-1:0] DataAreg;
    logic [DATA_W-1:0] DataBreg;
    logic [DATA_W-1:0] imm_valuereg;
    logic [REG_W-1:0]  RegRsreg;
    logic [REG_W-1:0]  RegRtreg;
    logic [REG_W-1:0]  RegRdreg;
    logic [OP_W-1:0]   RegOpCode;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output in_valid, bubble, flush, WB, M, EX, DataA, DataB, imm_value,
               RegRs, RegRt, RegRd, OpCode, out_ready,
        input  in_ready, out_valid, WBreg, Mreg, EXreg, DataAreg, DataBreg,
               imm_valuereg, RegRsreg, RegRtreg, RegRdreg, RegOpCode, stall_cnt
    );

    modport slave (
        input  in_valid, bubble, flush, WB, M, EX, DataA, DataB, imm_value,
               RegRs, RegRt, RegRd, OpCode, out_ready,
        output in_ready, out_valid, WBreg, Mreg, EXreg, DataAreg, DataBreg,
               imm_valuereg, RegRsreg, RegRtreg, RegRdreg, RegOpCode, stall_cnt
    );

endinterface

// File: rtl/pipe_skid_reg.sv
// Generic 2-entry elastic register: a main output entry plus a 1-deep skid entry.
// in_ready depends only on state, so no input reaches any output combinationally.
module pipe_skid_reg
    import idex_pkg::*;
#(
    parameter int                   PAYLOAD_W = 8,
    parameter logic [PAYLOAD_W-1:0] FLUSH_CLR = '0
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [PAYLOAD_W-1:0] in_data_i,
    input  logic                 flush_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [PAYLOAD_W-1:0] out_data_o
);

    skid_state_e          state_q;
    logic [PAYLOAD_W-1:0] main_q;
    logic [PAYLOAD_W-1:0] skid_q;
    logic                 accept;
    logic                 consume;

    assign in_ready_o  = (state_q != ST_SKID);
    assign out_valid_o = (state_q != ST_EMPTY);
    assign out_data_o  = main_q;
    assign accept      = in_valid_i && in_ready_o;
    assign consume     = out_valid_o && out_ready_i;

    // NOTE: non-blocking assignments so every register samples pre-edge values;
    // the payload registers are reset too because reset must present zeros on every output.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else if (flush_i) begin
            state_q <= ST_EMPTY;
            main_q  <= main_q & ~FLUSH_CLR;
            skid_q  <= skid_q & ~FLUSH_CLR;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_q  <= in_data_i;
                        state_q <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (accept && consume) begin
                        main_q <= in_data_i;
                    end else if (consume) begin
                        state_q <= ST_EMPTY;
                    end else if (accept) begin
                        skid_q  <= in_data_i;
                        state_q <= ST_SKID;
                    end
                end
                ST_SKID: begin
                    // Older skid entry always reaches main before anything newer is taken.
                    if (consume) begin
                        main_q  <= skid_q;
                        state_q <= ST_FULL;
                    end
                end
                default: state_q <= ST_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/idex_skid_stage.sv
// ID/EX pipeline stage with valid/ready handshake, skid buffer, flush, bubble insertion
// and a saturating stall counter.
module idex_skid_stage
    import idex_pkg::*;
#(
    parameter int DATA_W = IDEX_DATA_W,
    parameter int REG_W  = IDEX_REG_W,
    parameter int OP_W   = IDEX_OP_W,
    parameter int WB_W   = IDEX_WB_W,
    parameter int M_W    = IDEX_M_W,
    parameter int EX_W   = IDEX_EX_W,
    parameter int CNT_W  = IDEX_CNT_W
) (
    input logic              clock,
    input logic              rst,
    idex_skid_stage_if.slave bus
);

    typedef struct packed {
        logic [WB_W-1:0]   wb;
        logic [M_W-1:0]    m;
        logic [EX_W-1:0]   ex;
        logic [DATA_W-1:0] data_a;
        logic [DATA_W-1:0] data_b;
        logic [DATA_W-1:0] imm;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        logic [OP_W-1:0]   op;
    } payload_t;

    localparam int CTRL_W    = WB_W + M_W + EX_W;
    localparam int PAYLOAD_W = $bits(payload_t);
    localparam logic [PAYLOAD_W-1:0] CTRL_MASK =
        {{CTRL_W{1'b1}}, {(PAYLOAD_W - CTRL_W){1'b0}}};

    payload_t         in_pl;
    payload_t         out_pl;
    logic             out_valid;
    logic             in_ready;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    // NOTE: every field gets its value before the conditional override, so no latch is inferred.
    always_comb begin
        in_pl = '{wb: bus.WB, m: bus.M, ex: bus.EX,
                  data_a: bus.DataA, data_b: bus.DataB, imm: bus.imm_value,
                  rs: bus.RegRs, rt: bus.RegRt, rd: bus.RegRd, op: bus.OpCode};
        // Masking only matters when the entry is actually captured.
        if (bus.bubble) begin
            in_pl.wb = '0;
            in_pl.m  = '0;
            in_pl.ex = '0;
        end
    end

    pipe_skid_reg #(
        .PAYLOAD_W (PAYLOAD_W),
        .FLUSH_CLR (CTRL_MASK)
    ) u_skid (
        .clock       (clock),
        .rst         (rst),
        .in_valid_i  (bus.in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_pl),
        .flush_i     (bus.flush),
        .out_valid_o (out_valid),
        .out_ready_i (bus.out_ready),
        .out_data_o  (out_pl)
    );

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !bus.out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = out_valid;
    // Control fields read as a NOP whenever nothing valid is presented.
    assign bus.WBreg        = out_valid ? out_pl.wb : '0;
    assign bus.Mreg         = out_valid ? out_pl.m  : '0;
    assign bus.EXreg        = out_valid ? out_pl.ex : '0;
    assign bus.DataAreg     = out_pl.data_a;
    assign bus.DataBreg     = out_pl.data_b;
    assign bus.imm_valuereg = out_pl.imm;
    assign bus.RegRsreg     = out_pl.rs;
    assign bus.RegRtreg     = out_pl.rt;
    assign bus.RegRdreg     = out_pl.rd;
    assign bus.RegOpCode    = out_pl.op;
    assign bus.stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_idex_skid_stage.sv
// Bench for idex_skid_stage: a 2-deep queue model checked every cycle, plus directed
// scenarios with hand-computed expectations. A second instance with CNT_W=4 covers saturation.
module tb_idex_skid_stage;
    import idex_pkg::*;

    logic clock = 1'b0;
    logic rst;
    always #5 clock = ~clock;

    idex_skid_stage_if #(.CNT_W(16)) bus  ();
    idex_skid_stage_if #(.CNT_W(4))  bus4 ();

    idex_skid_stage #(.CNT_W(16)) dut  (.clock(clock), .rst(rst), .bus(bus));
    idex_skid_stage #(.CNT_W(4))  dut4 (.clock(clock), .rst(rst), .bus(bus4));

    assign bus4.in_valid  = bus.in_valid;
    assign bus4.bubble    = bus.bubble;
    assign bus4.flush     = bus.flush;
    assign bus4.WB        = bus.WB;
    assign bus4.M         = bus.M;
    assign bus4.EX        = bus.EX;
    assign bus4.DataA     = bus.DataA;
    assign bus4.DataB     = bus.DataB;
    assign bus4.imm_value = bus.imm_value;
    assign bus4.RegRs     = bus.RegRs;
    assign bus4.RegRt     = bus.RegRt;
    assign bus4.RegRd     = bus.RegRd;
    assign bus4.OpCode    = bus.OpCode;
    assign bus4.out_ready = bus.out_ready;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: the stage behaves as an in-order queue of at most two payloads.
    idex_payload_t mdl_q[$];
    int            raw_stall;

    always @(posedge clock or posedge rst) begin : model
        idex_payload_t p;
        bit acc;
        bit con;
        if (rst) begin
            mdl_q.delete();
            raw_stall = 0;
        end else begin
            p = '{wb: bus.WB, m: bus.M, ex: bus.EX, data_a: bus.DataA, data_b: bus.DataB,
                  imm: bus.imm_value, rs: bus.RegRs, rt: bus.RegRt, rd: bus.RegRd, op: bus.OpCode};
            if (bus.bubble) p = ctrl_nop(p);
            acc = bus.in_valid && (mdl_q.size() < 2);
            con = (mdl_q.size() > 0) && bus.out_ready;
            if ((mdl_q.size() > 0) && !bus.out_ready) raw_stall++;
            if (bus.flush) begin
                mdl_q.delete();
            end else begin
                if (con) void'(mdl_q.pop_front());
                if (acc) mdl_q.push_back(p);
            end
        end
    end

    always @(negedge clock) begin : compare
        idex_payload_t dp;
        idex_payload_t dp4;
        if (!rst) begin
            dp  = '{wb: bus.WBreg, m: bus.Mreg, ex: bus.EXreg, data_a: bus.DataAreg,
                    data_b: bus.DataBreg, imm: bus.imm_valuereg, rs: bus.RegRsreg,
                    rt: bus.RegRtreg, rd: bus.RegRdreg, op: bus.RegOpCode};
            dp4 = '{wb: bus4.WBreg, m: bus4.Mreg, ex: bus4.EXreg, data_a: bus4.DataAreg,
                    data_b: bus4.DataBreg, imm: bus4.imm_valuereg, rs: bus4.RegRsreg,
                    rt: bus4.RegRtreg, rd: bus4.RegRdreg, op: bus4.RegOpCode};
            check("mdl_in_ready",   bus.in_ready,   mdl_q.size() < 2);
            check("mdl_out_valid",  bus.out_valid,  mdl_q.size() != 0);
            check("mdl_in_ready4",  bus4.in_ready,  mdl_q.size() < 2);
            check("mdl_out_valid4", bus4.out_valid, mdl_q.size() != 0);
            check("mdl_stall_cnt",  bus.stall_cnt,  raw_stall);
            check("mdl_stall_cnt4", bus4.stall_cnt, (raw_stall > 15) ? 15 : raw_stall);
            if (mdl_q.size() != 0) begin
                check("mdl_payload",  dp,  mdl_q[0]);
                check("mdl_payload4", dp4, mdl_q[0]);
            end else begin
                check("mdl_ctrl_idle",  {bus.WBreg, bus.Mreg, bus.EXreg}, 9'h0);
                check("mdl_ctrl_idle4", {bus4.WBreg, bus4.Mreg, bus4.EXreg}, 9'h0);
            end
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        bus.bubble   = 1'b0;
        bus.flush    = 1'b0;
    endtask

    task automatic put(input logic [31:0] a, input logic [1:0] wb, input logic [2:0] m,
                       input logic [3:0] ex);
        bus.in_valid  = 1'b1;
        bus.DataA     = a;
        bus.DataB     = ~a;
        bus.imm_value = a * 3 + 7;
        bus.RegRs     = a[4:0];
        bus.RegRt     = a[9:5];
        bus.RegRd     = a[4:0] ^ 5'h1F;
        bus.OpCode    = a[5:0] + 6'd1;
        bus.WB        = wb;
        bus.M         = m;
        bus.EX        = ex;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        bus.out_ready = 1'b0;
        put(32'h0, 2'b0, 3'b0, 4'h0);
        bus.in_valid = 1'b0;
        #13;
        rst = 1'b0;
        tick();

        // Reset mid-cycle with a payload in flight and in_valid held high.
        bus.out_ready = 1'b0;
        put(32'h11, 2'b01, 3'b001, 4'h1);
        tick();
        put(32'h22, 2'b10, 3'b010, 4'h2);
        tick();
        check("skid_before_rst_in_ready", bus.in_ready, 1'b0);
        #1 rst = 1'b1;
        #1;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_in_ready",  bus.in_ready,  1'b1);
        check("rst_DataAreg",  bus.DataAreg,  32'h0);
        check("rst_DataBreg",  bus.DataBreg,  32'h0);
        check("rst_WBreg",     bus.WBreg,     2'b0);
        check("rst_stall_cnt", bus.stall_cnt, 16'h0);
        idle();
        #1 rst = 1'b0;
        tick();
        tick();
        check("post_rst_out_valid", bus.out_valid, 1'b0);

        // Streaming at full rate.
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            put(32'(i), 2'b01, 3'b100, 4'h6);
            tick();
            check("stream_DataAreg",  bus.DataAreg,  32'(i));
            check("stream_out_valid", bus.out_valid, 1'b1);
            check("stream_in_ready",  bus.in_ready,  1'b1);
        end
        idle();
        tick();
        check("stream_drained", bus.out_valid, 1'b0);

        // Backpressure into the skid entry, then release.
        do_reset();
        bus.out_ready = 1'b0;
        put(32'hA, 2'b01, 3'b010, 4'h3);
        tick();
        check("bp_first_DataAreg", bus.DataAreg, 32'hA);
        put(32'hB, 2'b10, 3'b001, 4'h4);
        tick();
        check("bp_in_ready",  bus.in_ready,  1'b0);
        check("bp_DataAreg",  bus.DataAreg,  32'hA);
        check("bp_stall_one", bus.stall_cnt, 16'd1);
        idle();
        repeat (3) tick();
        check("bp_hold_DataAreg", bus.DataAreg,  32'hA);
        check("bp_stall_four",    bus.stall_cnt, 16'd4);
        bus.out_ready = 1'b1;
        tick();
        check("bp_second_DataAreg", bus.DataAreg,  32'hB);
        check("bp_second_EXreg",    bus.EXreg,     4'h4);
        check("bp_release_ready",   bus.in_ready,  1'b1);
        tick();
        check("bp_drained",     bus.out_valid, 1'b0);
        check("bp_stall_final", bus.stall_cnt, 16'd4);

        // Bubble insertion.
        do_reset();
        bus.out_ready = 1'b1;
        bus.bubble    = 1'b1;
        put(32'h55, 2'b11, 3'b101, 4'hF);
        tick();
        check("bub_WBreg",     bus.WBreg,     2'b00);
        check("bub_Mreg",      bus.Mreg,      3'b000);
        check("bub_EXreg",     bus.EXreg,     4'h0);
        check("bub_DataAreg",  bus.DataAreg,  32'h55);
        check("bub_out_valid", bus.out_valid, 1'b1);
        bus.in_valid = 1'b0;
        tick();
        check("bub_no_accept", bus.out_valid, 1'b0);
        bus.bubble = 1'b0;
        put(32'h66, 2'b11, 3'b101, 4'hF);
        tick();
        check("nobub_WBreg", bus.WBreg, 2'b11);
        check("nobub_Mreg",  bus.Mreg,  3'b101);
        check("nobub_EXreg", bus.EXreg, 4'hF);
        idle();
        tick();
        bus.out_ready = 1'b0;
        put(32'h70, 2'b01, 3'b011, 4'h5);
        tick();
        put(32'h71, 2'b10, 3'b110, 4'h9);
        tick();
        bus.bubble = 1'b1;
        put(32'h72, 2'b11, 3'b111, 4'hE);
        tick();
        idle();
        bus.out_ready = 1'b1;
        tick();
        check("bub_refused_DataAreg", bus.DataAreg, 32'h71);
        check("bub_refused_WBreg",    bus.WBreg,    2'b10);
        check("bub_refused_Mreg",     bus.Mreg,     3'b110);
        check("bub_refused_EXreg",    bus.EXreg,    4'h9);
        tick();
        check("bub_refused_drained", bus.out_valid, 1'b0);

        // Flush in SKID with a simultaneous accept.
        do_reset();
        bus.out_ready = 1'b0;
        put(32'h1, 2'b11, 3'b111, 4'hF);
        tick();
        put(32'h2, 2'b11, 3'b111, 4'hF);
        tick();
        put(32'h3, 2'b11, 3'b111, 4'hF);
        bus.flush = 1'b1;
        tick();
        check("flush_out_valid", bus.out_valid, 1'b0);
        check("flush_in_ready",  bus.in_ready,  1'b1);
        check("flush_EXreg",     bus.EXreg,     4'h0);
        check("flush_stall_cnt", bus.stall_cnt, 16'd2);
        idle();
        bus.out_ready = 1'b1;
        repeat (4) begin
            tick();
            check("flush_nothing_emerges", bus.out_valid, 1'b0);
        end
        put(32'h4, 2'b01, 3'b001, 4'h1);
        tick();
        put(32'h5, 2'b01, 3'b001, 4'h1);
        bus.flush = 1'b1;
        tick();
        check("flush_consume_out_valid", bus.out_valid, 1'b0);
        idle();
        tick();
        check("flush_consume_empty", bus.out_valid, 1'b0);

        // Stall counter saturation on the CNT_W=4 instance.
        do_reset();
        bus.out_ready = 1'b0;
        put(32'h99, 2'b01, 3'b001, 4'h1);
        tick();
        idle();
        repeat (20) tick();
        check("sat_stall_cnt4", bus4.stall_cnt, 4'hF);
        check("sat_stall_cnt",  bus.stall_cnt,  16'd20);
        repeat (3) tick();
        check("sat_hold_cnt4", bus4.stall_cnt, 4'hF);
        check("sat_hold_cnt",  bus.stall_cnt,  16'd23);
        check("sat_DataAreg",  bus.DataAreg,   32'h99);

        // Mixed traffic: overlapping handshake, bubble and flush patterns.
        do_reset();
        for (int i = 0; i < 60; i++) begin
            put(32'h100 + 32'(i), 2'(i), 3'(i + 1), 4'(i + 2));
            bus.in_valid  = (i % 3) != 2;
            bus.out_ready = (i % 4) != 0;
            bus.bubble    = (i % 7) == 3;
            bus.flush     = (i == 37);
            tick();
        end
        idle();
        bus.out_ready = 1'b1;
        repeat (3) tick();
        check("mixed_drained", bus.out_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
